// File: rtl/exe_pkg.sv
// Shared types for the execute-stage ALU: operation codes, FSM states, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exe_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [3:0] {
        SEL_SHL  = 4'h0,
        SEL_SHR  = 4'h1,
        SEL_MUL  = 4'h2,
        SEL_MULU = 4'h3,
        SEL_DIV  = 4'h4,
        SEL_DIVU = 4'h5,
        SEL_ADD  = 4'h6,
        SEL_ADDU = 4'h7,
        SEL_SUB  = 4'h8,
        SEL_SUBU = 4'h9,
        SEL_AND  = 4'hA,
        SEL_OR   = 4'hB,
        SEL_XOR  = 4'hC,
        SEL_NOR  = 4'hD,
        SEL_SLT  = 4'hE,
        SEL_SLTU = 4'hF
    } alu_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    function automatic logic is_muldiv(input alu_sel_e sel);
        return (sel == SEL_MUL) || (sel == SEL_MULU) || (sel == SEL_DIV) || (sel == SEL_DIVU);
    endfunction

endpackage

// File: rtl/exe_alu_if.sv
// Decode-to-ALU operation bus plus the ALU result bus toward writeback.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side; out_valid is a pulse with no backpressure.
interface exe_alu_if import exe_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Overflow;
    logic             Zero;

    // master: decode side issuing operations and observing results
    modport master (
        output in_valid, ALU_Sel, A, B,
        input  in_ready, out_valid, Result, Hi, Lo, Overflow, Zero
    );

    // slave: the ALU itself
    modport slave (
        input  in_valid, ALU_Sel, A, B,
        output in_ready, out_valid, Result, Hi, Lo, Overflow, Zero
    );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative multiply (shift-add) / divide (restoring) on magnitudes, with a separate sign-fix step.
// Latency: start loads operands, then WIDTH iteration cycles (last_o on the final one), then fix_i.
// Backpressure: none; the owner must not pulse start_i while iterating.
// Ports: clk, rst (async active-low), start_i/signed_i/is_div_i/a_i/b_i load an op,
//        fix_i applies sign correction, hi_o/lo_o/ovf_o carry the result, last_o flags the final iteration.
module exe_muldiv import exe_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             fix_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   hi_q, lo_q, op_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q, div_q, neg_q, rneg_q, bz_q, ovf_q;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_rs, div_diff;
    logic [2*WIDTH-1:0] prod_neg;

    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // Multiply: hi accumulates the multiplicand while lo shifts the multiplier out LSB first.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    assign div_rs   = {hi_q, lo_q[WIDTH-1]};
    assign div_diff = div_rs - {1'b0, op_q};
    assign prod_neg = -{hi_q, lo_q};

    assign last_o = run_q && (cnt_q == CW'(WIDTH-1));
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign ovf_o  = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            bz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (start_i) begin
            hi_q   <= '0;
            lo_q   <= is_div_i ? a_mag : b_mag;
            op_q   <= is_div_i ? b_mag : a_mag;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            div_q  <= is_div_i;
            neg_q  <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q <= signed_i && a_i[WIDTH-1];
            bz_q   <= (b_i == '0);
            ovf_q  <= signed_i && is_div_i && (a_i == MIN_VAL) && (b_i == '1);
        end else if (run_q) begin
            if (div_q) begin
                if (!div_diff[WIDTH]) begin
                    hi_q <= div_diff[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_q <= div_rs[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_q <= mul_sum[WIDTH:1];
                lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (last_o) begin
                run_q <= 1'b0;
            end
        end else if (fix_i) begin
            if (div_q) begin
                // Divide by zero leaves the remainder equal to |A|; its sign fix then restores A.
                if (bz_q) begin
                    lo_q <= '1;
                end else if (neg_q) begin
                    lo_q <= -lo_q;
                end
                if (rneg_q) begin
                    hi_q <= -hi_q;
                end
            end else if (neg_q) begin
                {hi_q, lo_q} <= prod_neg;
            end
        end
    end
endmodule

// File: rtl/exe_alu.sv
// Execute-stage ALU: single-cycle shift/arith/logic/compare, iterative mul/div into HI/LO.
// Latency: single-cycle ops 1 cycle; mul/div WIDTH+2 cycles from accept to out_valid.
// Backpressure: in_ready low while mul/div runs (requests are not queued); out_valid pulse has none.
// Ports: clk, rst (async active-low), io (exe_alu_if.slave: in_valid/in_ready/ALU_Sel/A/B in,
//        out_valid/Result/Hi/Lo/Overflow/Zero out).
module exe_alu import exe_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input  logic    clk,
    input  logic    rst,
    exe_alu_if.slave io
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    logic             fix_ph_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             ovf_q, zero_q, out_vld_q;

    alu_sel_e         sel;
    logic             accept, md_start, md_signed, md_div, md_fix;
    logic [WIDTH-1:0] sum, diff, sc_res;
    logic [SHW-1:0]   shamt;
    logic             sc_ovf;
    logic             core_last, core_ovf;
    logic [WIDTH-1:0] core_hi, core_lo;

    assign sel       = alu_sel_e'(io.ALU_Sel);
    assign accept    = io.in_valid && (state_q == IDLE);
    assign md_start  = accept && is_muldiv(sel);
    assign md_signed = (sel == SEL_MUL) || (sel == SEL_DIV);
    assign md_div    = (sel == SEL_DIV) || (sel == SEL_DIVU);
    // FIX spans two cycles: sign correction inside the core, then capture into the output registers.
    assign md_fix    = (state_q == FIX) && !fix_ph_q;

    assign sum   = io.A + io.B;
    assign diff  = io.A - io.B;
    assign shamt = io.B[SHW-1:0];

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (sel)
            SEL_SHL:  sc_res = io.A << shamt;
            SEL_SHR:  sc_res = io.A >> shamt;
            SEL_ADD: begin
                sc_res = sum;
                sc_ovf = (io.A[WIDTH-1] == io.B[WIDTH-1]) && (sum[WIDTH-1] != io.A[WIDTH-1]);
            end
            SEL_ADDU: sc_res = sum;
            SEL_SUB: begin
                sc_res = diff;
                sc_ovf = (io.A[WIDTH-1] != io.B[WIDTH-1]) && (diff[WIDTH-1] != io.A[WIDTH-1]);
            end
            SEL_SUBU: sc_res = diff;
            SEL_AND:  sc_res = io.A & io.B;
            SEL_OR:   sc_res = io.A | io.B;
            SEL_XOR:  sc_res = io.A ^ io.B;
            SEL_NOR:  sc_res = ~(io.A | io.B);
            SEL_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(io.A) < $signed(io.B))};
            SEL_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (io.A < io.B)};
            default:  sc_res = '0;
        endcase
    end

    exe_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .signed_i (md_signed),
        .is_div_i (md_div),
        .a_i      (io.A),
        .b_i      (io.B),
        .fix_i    (md_fix),
        .last_o   (core_last),
        .hi_o     (core_hi),
        .lo_o     (core_lo),
        .ovf_o    (core_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            fix_ph_q  <= 1'b0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= 1'b0;
            zero_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_muldiv(sel)) begin
                            state_q <= md_div ? DIV : MUL;
                        end else begin
                            result_q  <= sc_res;
                            ovf_q     <= sc_ovf;
                            zero_q    <= (sc_res == '0);
                            out_vld_q <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    if (core_last) begin
                        state_q  <= FIX;
                        fix_ph_q <= 1'b0;
                    end
                end
                FIX: begin
                    if (!fix_ph_q) begin
                        fix_ph_q <= 1'b1;
                    end else begin
                        result_q  <= core_lo;
                        hi_q      <= core_hi;
                        lo_q      <= core_lo;
                        ovf_q     <= core_ovf;
                        zero_q    <= (core_lo == '0);
                        out_vld_q <= 1'b1;
                        fix_ph_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = out_vld_q;
    assign io.Result    = result_q;
    assign io.Hi        = hi_q;
    assign io.Lo        = lo_q;
    assign io.Overflow  = ovf_q;
    assign io.Zero      = zero_q;
endmodule

// File: tb/tb_exe_alu.sv
// Directed bench for exe_alu: reset, single-cycle ops, back-to-back, mul/div, busy hold, mid-op reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_exe_alu;
    import exe_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    exe_alu_if #(.WIDTH(32)) io ();

    exe_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Present one op and let it transfer on the next edge; caller is 1 time unit after an edge.
    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        io.ALU_Sel  = sel;
        io.A        = a;
        io.B        = b;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    // Issue a mul/div and wait for its result pulse (bounded); optionally hold in_valid while busy.
    task automatic do_md(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int lat, output int low);
        io.ALU_Sel  = sel;
        io.A        = a;
        io.B        = b;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = hold;
        lat = 0;
        low = 0;
        while (io.out_valid !== 1'b1 && lat < 200) begin
            if (io.in_ready === 1'b0) low++;
            @(posedge clk); #1;
            lat++;
        end
        io.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (io.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", io.in_ready); end
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", io.out_valid); end
        checks++; if (io.Result !== 32'h0)   begin errors++; $display("FAIL reset_result got %h want 0", io.Result); end
        checks++; if (io.Hi !== 32'h0)       begin errors++; $display("FAIL reset_hi got %h want 0", io.Hi); end
        checks++; if (io.Lo !== 32'h0)       begin errors++; $display("FAIL reset_lo got %h want 0", io.Lo); end
        checks++; if (io.Overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b want 0", io.Overflow); end
        checks++; if (io.Zero !== 1'b0)      begin errors++; $display("FAIL reset_zero got %b want 0", io.Zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [3:0]  t_sel [13] = '{4'h6, 4'h7, 4'h8, 4'h9, 4'h0, 4'h0, 4'h1, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h6};
        logic [31:0] t_a   [13] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h1, 32'h12345678,
                                    32'hF0000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 32'h1, 32'hFFFFFFFF};
        logic [31:0] t_b   [13] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h4, 32'h0,
                                    32'h24, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h0, 32'hFFFFFFFF, 32'h1};
        logic [31:0] t_res [13] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h10, 32'h12345678,
                                    32'h0F000000, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic        t_ovf [13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        t_zero[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 13; i++) begin
            issue(t_sel[i], t_a[i], t_b[i]);
            checks++; if (io.out_valid !== 1'b1)   begin errors++; $display("FAIL single_vld[%0d] got %b want 1", i, io.out_valid); end
            checks++; if (io.Result !== t_res[i])  begin errors++; $display("FAIL single_res[%0d] got %h want %h", i, io.Result, t_res[i]); end
            checks++; if (io.Overflow !== t_ovf[i]) begin errors++; $display("FAIL single_ovf[%0d] got %b want %b", i, io.Overflow, t_ovf[i]); end
            checks++; if (io.Zero !== t_zero[i])   begin errors++; $display("FAIL single_zero[%0d] got %b want %b", i, io.Zero, t_zero[i]); end
        end
        @(posedge clk); #1;
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", io.out_valid); end
        checks++; if (io.Hi !== 32'h0 || io.Lo !== 32'h0) begin errors++; $display("FAIL single_hilo got %h/%h want 0/0", io.Hi, io.Lo); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  s [4] = '{4'h8, 4'hE, 4'hF, 4'h1};
        logic [31:0] a [4] = '{32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] b [4] = '{32'h5, 32'h1, 32'h1, 32'd31};
        logic [31:0] r [4] = '{32'h0, 32'h1, 32'h0, 32'h1};
        logic        z [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            io.ALU_Sel = s[i]; io.A = a[i]; io.B = b[i]; io.in_valid = 1'b1;
            @(posedge clk); #1;
            if (io.out_valid === 1'b1) pulses++;
            checks++; if (io.Result !== r[i]) begin errors++; $display("FAIL b2b_res[%0d] got %h want %h", i, io.Result, r[i]); end
            checks++; if (io.Zero !== z[i])   begin errors++; $display("FAIL b2b_zero[%0d] got %b want %b", i, io.Zero, z[i]); end
        end
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        if (io.out_valid === 1'b1) pulses++;
        checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
    endtask

    task automatic test_mul;
        int lat, low;
        do_md(4'h2, 32'hFFFFFFFD, 32'h5, 1'b0, lat, low);
        checks++; if (lat != 34)  begin errors++; $display("FAIL mul_latency got %0d want 34", lat); end
        checks++; if (low != 34)  begin errors++; $display("FAIL mul_busy_cycles got %0d want 34", low); end
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL mul_ready_at_done got %b want 1", io.in_ready); end
        checks++; if (io.Hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul_hi got %h want FFFFFFFF", io.Hi); end
        checks++; if (io.Lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mul_lo got %h want FFFFFFF1", io.Lo); end
        checks++; if (io.Result !== 32'hFFFFFFF1) begin errors++; $display("FAIL mul_res got %h want FFFFFFF1", io.Result); end
        checks++; if (io.Overflow !== 1'b0) begin errors++; $display("FAIL mul_ovf got %b want 0", io.Overflow); end
        @(posedge clk); #1;
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL mul_pulse got %b want 0", io.out_valid); end
        do_md(4'h3, 32'hFFFFFFFF, 32'h2, 1'b0, lat, low);
        checks++; if (lat != 34) begin errors++; $display("FAIL mulu_latency got %0d want 34", lat); end
        checks++; if (io.Hi !== 32'h1) begin errors++; $display("FAIL mulu_hi got %h want 1", io.Hi); end
        checks++; if (io.Lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulu_lo got %h want FFFFFFFE", io.Lo); end
    endtask

    task automatic test_div;
        int lat, low;
        do_md(4'h4, 32'hFFFFFFF9, 32'h2, 1'b0, lat, low);
        checks++; if (lat != 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
        checks++; if (io.Lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want FFFFFFFD", io.Lo); end
        checks++; if (io.Hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want FFFFFFFF", io.Hi); end
        checks++; if (io.Result !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_res got %h want FFFFFFFD", io.Result); end
        @(posedge clk); #1;
        do_md(4'h5, 32'h9, 32'h0, 1'b0, lat, low);
        checks++; if (io.Lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo got %h want FFFFFFFF", io.Lo); end
        checks++; if (io.Hi !== 32'h9) begin errors++; $display("FAIL divu0_hi got %h want 9", io.Hi); end
        checks++; if (io.Overflow !== 1'b0) begin errors++; $display("FAIL divu0_ovf got %b want 0", io.Overflow); end
    endtask

    task automatic test_div_ovf_hold;
        int lat, low;
        @(posedge clk); #1;
        do_md(4'h4, 32'h80000000, 32'hFFFFFFFF, 1'b1, lat, low);
        checks++; if (lat != 34) begin errors++; $display("FAIL hold_latency got %0d want 34", lat); end
        checks++; if (low != 34) begin errors++; $display("FAIL hold_busy_cycles got %0d want 34", low); end
        checks++; if (io.Lo !== 32'h80000000) begin errors++; $display("FAIL divmin_lo got %h want 80000000", io.Lo); end
        checks++; if (io.Hi !== 32'h0) begin errors++; $display("FAIL divmin_hi got %h want 0", io.Hi); end
        checks++; if (io.Overflow !== 1'b1) begin errors++; $display("FAIL divmin_ovf got %b want 1", io.Overflow); end
        @(posedge clk); #1;
        checks++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_no_extra got vld=%b rdy=%b want vld=0 rdy=1", io.out_valid, io.in_ready);
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        io.ALU_Sel = 4'h4; io.A = 32'd100; io.B = 32'd7; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (io.Hi !== 32'h0 || io.Lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got %h/%h want 0/0", io.Hi, io.Lo); end
        repeat (3) begin
            @(posedge clk); #1;
            if (io.out_valid === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        #1;
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", io.in_ready); end
        repeat (40) begin
            @(posedge clk); #1;
            if (io.out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
        checks++; if (io.Lo !== 32'h0) begin errors++; $display("FAIL midrst_lo_after got %h want 0", io.Lo); end
        issue(4'h6, 32'h2, 32'h3);
        checks++; if (io.out_valid !== 1'b1 || io.Result !== 32'h5) begin
            errors++; $display("FAIL midrst_add got vld=%b res=%h want vld=1 res=5", io.out_valid, io.Result);
        end
    endtask

    initial begin
        io.in_valid = 1'b0;
        io.ALU_Sel  = 4'h0;
        io.A        = 32'h0;
        io.B        = 32'h0;
        rst_n       = 1'b0;
        #1;
        test_reset;
        test_single;
        test_back_to_back;
        test_mul;
        test_div;
        test_div_ovf_hold;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
